// File: rtl/alu_writeback_if.sv
// alu_writeback_if: operand issue and register-file write-back bundle for alu_writeback_stage
interface alu_writeback_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic in_valid;
  logic in_ready;
  logic [2:0] in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0] in_dest;
  logic wb_valid;
  logic wb_ready;
  logic wb_we;
  logic [2:0] wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic wb_zero;
  logic wb_carry;
  logic [7:0] pending_mask;
  logic [CNT_W-1:0] retired_cnt;
  modport master (
    output in_valid, in_op, in_a, in_b, in_dest, wb_ready,
    input in_ready, wb_valid, wb_we, wb_reg, wb_data, wb_zero, wb_carry, pending_mask, retired_cnt
  );
  modport slave (
    input in_valid, in_op, in_a, in_b, in_dest, wb_ready,
    output in_ready, wb_valid, wb_we, wb_reg, wb_data, wb_zero, wb_carry, pending_mask, retired_cnt
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: two-stage ALU execute feeding the register-file write port, with RAW hazard mask
module alu_writeback_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  alu_writeback_if.slave bus
);
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic s1_adv;
  logic accept;
  logic retire;
  logic [2:0] s1_op;
  logic [2:0] s1_dest;
  logic [2:0] s2_dest;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s2_data;
  logic s2_zero;
  logic s2_carry;
  logic [WIDTH:0] res;
  logic [CNT_W-1:0] cnt;
  assign s2_free = !s2_valid || bus.wb_ready;
  assign s1_adv = s1_valid && s2_free;
  assign accept = bus.in_valid && bus.in_ready;
  assign retire = s2_valid && bus.wb_ready;
  // res[WIDTH] carries the carry/borrow/shifted-out bit for every opcode
  always_comb begin
    res = '0;
    case (s1_op)
      3'd0: res = {1'b0, s1_a} + {1'b0, s1_b};
      3'd1: res = {1'b0, s1_a} - {1'b0, s1_b};
      3'd2: res = {1'b0, s1_a & s1_b};
      3'd3: res = {1'b0, s1_a | s1_b};
      3'd4: res = {1'b0, s1_a ^ s1_b};
      3'd5: res = {{WIDTH{1'b0}}, s1_a < s1_b};
      3'd6: res = {s1_a, 1'b0};
      default: res = {s1_a[0], 1'b0, s1_a[WIDTH-1:1]};
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op <= '0;
      s1_a <= '0;
      s1_b <= '0;
      s1_dest <= '0;
      s2_valid <= 1'b0;
      s2_data <= '0;
      s2_dest <= '0;
      s2_zero <= 1'b0;
      s2_carry <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op <= bus.in_op;
        s1_a <= bus.in_a;
        s1_b <= bus.in_b;
        s1_dest <= bus.in_dest;
      end else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data <= res[WIDTH-1:0];
        s2_dest <= s1_dest;
        s2_zero <= res[WIDTH-1:0] == '0;
        s2_carry <= res[WIDTH];
      end else if (retire) s2_valid <= 1'b0;
      if (retire) cnt <= cnt + 1'b1;
    end
  end
  assign bus.in_ready = !s1_valid || s2_free;
  assign bus.wb_valid = s2_valid;
  assign bus.wb_we = retire && s2_dest != 3'd0;
  assign bus.wb_reg = s2_dest;
  assign bus.wb_data = s2_data;
  assign bus.wb_zero = s2_zero;
  assign bus.wb_carry = s2_carry;
  // register 0 is hardwired, so it never needs a hazard stall
  assign bus.pending_mask = ((s1_valid ? 8'b1 << s1_dest : 8'b0) | (s2_valid ? 8'b1 << s2_dest : 8'b0)) & 8'hFE;
  assign bus.retired_cnt = cnt;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed stimulus with a scoreboard of expected write-backs
module tb_alu_writeback_stage;
  typedef struct packed {
    logic [2:0] dest;
    logic [3:0] data;
    logic zero;
    logic carry;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  int t0;
  logic [7:0] exp_cnt = 0;
  logic [7:0] mm;
  ent_t e;
  ent_t sb[$];
  alu_writeback_if #(.WIDTH(4), .CNT_W(8)) bus();
  alu_writeback_stage #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic ent_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [2:0] d);
    int ai = int'(a);
    int bi = int'(b);
    int r = 0;
    int c = 0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 15) ? 1 : 0; end
      3'd1: begin r = ai - bi; c = (ai < bi) ? 1 : 0; end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: r = (ai < bi) ? 1 : 0;
      3'd6: begin r = ai * 2; c = (ai >= 8) ? 1 : 0; end
      default: begin r = ai / 2; c = ai % 2; end
    endcase
    r = r & 15;
    model = '{dest: d, data: 4'(r), zero: (r == 0), carry: c[0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [2:0] d);
    int n = 0;
    bus.in_valid = 1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_dest = d;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
  endtask
  always @(negedge clk) if (!rst) begin
    mm = 0;
    foreach (sb[i]) mm |= 8'b1 << sb[i].dest;
    chk("pending_mask", 32'(bus.pending_mask), 32'(mm & 8'hFE));
    chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < 2 || bus.wb_ready));
    chk("retired_cnt", 32'(bus.retired_cnt), 32'(exp_cnt));
    if (bus.wb_valid && bus.wb_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_reg", 32'(bus.wb_reg), 32'(e.dest));
        chk("wb_data", 32'(bus.wb_data), 32'(e.data));
        chk("wb_zero", 32'(bus.wb_zero), 32'(e.zero));
        chk("wb_carry", 32'(bus.wb_carry), 32'(e.carry));
        chk("wb_we", 32'(bus.wb_we), 32'(e.dest != 0));
      end
      exp_cnt++;
    end else chk("wb_we_idle", 32'(bus.wb_we), 0);
    if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_op, bus.in_a, bus.in_b, bus.in_dest));
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 0;
    bus.in_op = 0;
    bus.in_a = 0;
    bus.in_b = 0;
    bus.in_dest = 0;
    bus.wb_ready = 1;
    #12;
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_wb_we", 32'(bus.wb_we), 0);
    chk("rst_wb_reg", 32'(bus.wb_reg), 0);
    chk("rst_wb_data", 32'(bus.wb_data), 0);
    chk("rst_wb_zero", 32'(bus.wb_zero), 0);
    chk("rst_wb_carry", 32'(bus.wb_carry), 0);
    chk("rst_pending", 32'(bus.pending_mask), 0);
    chk("rst_retired", 32'(bus.retired_cnt), 0);
    tick();
    rst = 0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    tick();
    send(0, 4'hF, 4'h2, 3);
    chk("add_s1_only", 32'(bus.wb_valid), 0);
    chk("add_pending", 32'(bus.pending_mask), 'h08);
    tick();
    chk("add_valid", 32'(bus.wb_valid), 1);
    chk("add_we", 32'(bus.wb_we), 1);
    chk("add_reg", 32'(bus.wb_reg), 3);
    chk("add_data", 32'(bus.wb_data), 'h1);
    chk("add_carry", 32'(bus.wb_carry), 1);
    chk("add_zero", 32'(bus.wb_zero), 0);
    tick();
    send(1, 4'h3, 4'h5, 1);
    send(1, 4'h7, 4'h7, 2);
    chk("sub_borrow_data", 32'(bus.wb_data), 'hE);
    chk("sub_borrow_carry", 32'(bus.wb_carry), 1);
    tick();
    chk("sub_zero_data", 32'(bus.wb_data), 0);
    chk("sub_zero_flag", 32'(bus.wb_zero), 1);
    chk("sub_zero_carry", 32'(bus.wb_carry), 0);
    tick();
    send(4, 4'h5, 4'h5, 0);
    chk("x0_pending", 32'(bus.pending_mask), 0);
    tick();
    chk("x0_valid", 32'(bus.wb_valid), 1);
    chk("x0_we", 32'(bus.wb_we), 0);
    tick();
    bus.wb_ready = 0;
    send(0, 4'h1, 4'h2, 1);
    send(2, 4'h6, 4'h3, 2);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_pending", 32'(bus.pending_mask), 'h06);
    fork
      begin
        send(6, 4'h9, 4'h0, 3);
        send(7, 4'h5, 4'h0, 4);
      end
      begin
        repeat (3) tick();
        chk("bp_hold_reg", 32'(bus.wb_reg), 1);
        chk("bp_hold_data", 32'(bus.wb_data), 'h3);
        chk("bp_hold_ready", 32'(bus.in_ready), 0);
        bus.wb_ready = 1;
      end
    join
    repeat (4) tick();
    chk("bp_drained", 32'(sb.size()), 0);
    bus.wb_ready = 0;
    send(3, 4'h1, 4'h2, 5);
    send(5, 4'h1, 4'h2, 6);
    #3;
    rst = 1;
    sb.delete();
    exp_cnt = 0;
    #1;
    chk("midrst_wb_valid", 32'(bus.wb_valid), 0);
    chk("midrst_pending", 32'(bus.pending_mask), 0);
    chk("midrst_retired", 32'(bus.retired_cnt), 0);
    @(posedge clk);
    #1;
    rst = 0;
    bus.wb_ready = 1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    repeat (3) tick();
    chk("midrst_no_wb", 32'(bus.wb_valid), 0);
    t0 = cyc;
    for (int i = 0; i < 256; i++)
      send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));
    chk("throughput", 32'(cyc - t0), 256);
    repeat (3) tick();
    chk("wrap_drained", 32'(sb.size()), 0);
    chk("wrap_cnt", 32'(bus.retired_cnt), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
